// File: rtl/apb_master_q.sv
// Queued APB4 master: command FIFO, lane alignment, strobes, response pulse.
// Define APB_TIMEOUT_EN to abandon ACCESS after TIMEOUT_CYCLES wait states.
module apb_master_q #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_wr,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [1:0]              cmd_size,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    busy,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFF_W      = $clog2(STRB_WIDTH);
  localparam int PTR_W      = $clog2(DEPTH);
  localparam int LVL_W      = PTR_W + 1;

  localparam logic [1:0] MAX_SIZE = 2'(OFF_W);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
    $error("apb_master_q: DATA_WIDTH must be 32 or 64");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("apb_master_q: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_to
    $error("apb_master_q: TIMEOUT_CYCLES must be >= 1");
  end

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            size;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  cmd_t             mem [DEPTH];
  cmd_t             cmd_in;
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

  logic [1:0] state;
  logic [1:0] state_n;
  logic       done;
  logic       timeout_hit;

  logic [1:0]            size_c;
  logic [ADDR_WIDTH-1:0] lo_mask;
  logic [ADDR_WIDTH-1:0] addr_al;
  logic [OFF_W-1:0]      off;
  logic [3:0]            nbytes;
  logic [STRB_WIDTH-1:0] strb_base;
  logic [STRB_WIDTH-1:0] strb_al;
  logic [DATA_WIDTH-1:0] wdata_al;

  logic [OFF_W-1:0]      hold_off;
  logic [1:0]            hold_size;
  logic [6:0]            nbits;
  logic [DATA_WIDTH-1:0] dmask;
  logic [DATA_WIDTH-1:0] rdata_al;

  assign empty     = (fifo_level == '0);
  assign full      = (fifo_level == LVL_W'(DEPTH));
  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;

  assign cmd_in = '{wr: cmd_wr, addr: cmd_addr,
                    size: cmd_size, wdata: cmd_wdata};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cmd_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Head entry is aligned and lane-shifted before it reaches the bus regs.
  always_comb begin
    head      = mem[rd_ptr];
    size_c    = (head.size > MAX_SIZE) ? MAX_SIZE : head.size;
    lo_mask   = (ADDR_WIDTH'(1) << size_c) - ADDR_WIDTH'(1);
    addr_al   = head.addr & ~lo_mask;
    off       = addr_al[OFF_W-1:0];
    nbytes    = 4'd1 << size_c;
    strb_base = '0;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      strb_base[i] = (i < int'(nbytes));
    end
    strb_al   = head.wr ? (strb_base << off) : '0;
    wdata_al  = head.wdata << {off, 3'b000};
  end

  always_comb begin
    nbits = 7'd8 << hold_size;
    dmask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      dmask[i] = (i < int'(nbits));
    end
    rdata_al = (prdata >> {hold_off, 3'b000}) & dmask;
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !pready) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Limit edge: this wait cycle would bring the count to TIMEOUT_CYCLES.
  assign timeout_hit = (state == ACCESS) && !pready &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign done = (state == ACCESS) && (pready || timeout_hit);
  assign pop  = !empty && ((state == IDLE) || done);

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_n = SETUP;
        end
      end
      SETUP: begin
        state_n = ACCESS;
      end
      ACCESS: begin
        if (done) begin
          state_n = empty ? IDLE : SETUP;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      hold_off  <= '0;
      hold_size <= '0;
    end else begin
      state <= state_n;
      if (pop) begin
        pwrite    <= head.wr;
        paddr     <= addr_al;
        pwdata    <= wdata_al;
        pstrb     <= strb_al;
        hold_off  <= off;
        hold_size <= size_c;
      end else if (done) begin
        pwrite    <= 1'b0;
        paddr     <= '0;
        pwdata    <= '0;
        pstrb     <= '0;
      end
    end
  end

  assign psel    = (state != IDLE);
  assign penable = (state == ACCESS);
  assign busy    = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid   <= done;
      rsp_timeout <= done && timeout_hit;
      rsp_err     <= done && (timeout_hit || pslverr);
      rsp_rdata   <= (done && !pwrite && !timeout_hit) ? rdata_al : '0;
    end
  end

endmodule

// File: tb/tb_apb_master_q.sv
// Directed scoreboard bench for apb_master_q (DATA_WIDTH 32, DEPTH 4).
// Timeout scenario is included when APB_TIMEOUT_EN is defined.
module tb_apb_master_q;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TO    = 16;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } bus_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [1:0]    cmd_size;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [2:0]    fifo_level;
  logic          busy;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [3:0]    pstrb;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   last_push;
  bus_t bus_q[$];
  rsp_t rsp_q[$];
  int   rsp_cyc_q[$];
  bus_t acc_exp;

  apb_master_q #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_wr     (cmd_wr),
    .cmd_addr   (cmd_addr),
    .cmd_size   (cmd_size),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .fifo_level (fifo_level),
    .busy       (busy),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pstrb      (pstrb),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic wr, input logic [31:0] addr,
                      input logic [1:0] size, input logic [31:0] wdata,
                      input bus_t eb, input rsp_t er,
                      input bit cb, input bit cr);
    int n;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_size  = size;
    cmd_wdata = wdata;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 64) begin
      n++;
      @(negedge clk);
    end
    chk("push_accept", 64'(n < 64), 1);
    if (cb) bus_q.push_back(eb);
    if (cr) rsp_q.push_back(er);
    @(posedge clk);
    #1;
    last_push = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || rsp_valid) && n < 200);
    chk("idle_reached", 64'(n < 200), 1);
  endtask

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (!psel) begin
        chk("idle_paddr", paddr, 0);
        chk("idle_ctl", {penable, pwrite, pstrb, pwdata}, 0);
      end else if (!penable) begin
        chk("setup_expected", 64'(bus_q.size() != 0), 1);
        if (bus_q.size() != 0) begin
          acc_exp = bus_q.pop_front();
          chk("setup_pwrite", pwrite, acc_exp.wr);
          chk("setup_paddr", paddr, acc_exp.addr);
          chk("setup_pstrb", pstrb, acc_exp.strb);
          chk("setup_pwdata", pwdata, acc_exp.wdata);
        end
      end else begin
        chk("access_paddr", paddr, acc_exp.addr);
        chk("access_ctl", {pwrite, pstrb, pwdata},
            {acc_exp.wr, acc_exp.strb, acc_exp.wdata});
      end
    end
  end

  always @(negedge clk) begin
    rsp_t er;
    if (rsp_valid === 1'b1) begin
      rsp_cyc_q.push_back(cyc);
      chk("rsp_expected", 64'(rsp_q.size() != 0), 1);
      if (rsp_q.size() != 0) begin
        er = rsp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, er.rdata);
        chk("rsp_err", rsp_err, er.err);
        chk("rsp_timeout", rsp_timeout, er.to);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish by 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    int acc;
    int b0;
    int nr;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_size  = '0;
    cmd_wdata = '0;
    prdata    = '0;
    pready    = 1'b1;
    pslverr   = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_level", fifo_level, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_psel", psel, 0);

    // word write, zero wait, latency
    @(posedge clk);
    #1;
    push(1'b1, 32'h104, 2'd2, 32'hDEADBEEF,
         bus_t'{1'b1, 32'h104, 4'hF, 32'hDEADBEEF},
         rsp_t'{32'h0, 1'b0, 1'b0}, 1'b1, 1'b1);
    p = last_push;
    @(negedge clk);
    chk("lat_level_n0", fifo_level, 1);
    chk("lat_busy_n0", busy, 1);
    @(negedge clk);
    chk("lat_setup_n1", {psel, penable}, 2'b10);
    chk("lat_level_n1", fifo_level, 0);
    @(negedge clk);
    chk("lat_access_n2", {psel, penable}, 2'b11);
    @(negedge clk);
    chk("lat_rsp_n3", rsp_valid, 1);
    chk("lat_rsp_cycle", cyc - p, 3);
    @(negedge clk);
    chk("rsp_pulse_end", rsp_valid, 0);
    chk("idle_busy", busy, 0);

    // byte read on lane 3
    prdata = 32'hA5000000;
    @(posedge clk);
    #1;
    push(1'b0, 32'h13, 2'd0, 32'h0,
         bus_t'{1'b0, 32'h13, 4'h0, 32'h0},
         rsp_t'{32'h000000A5, 1'b0, 1'b0}, 1'b1, 1'b1);
    wait_idle();

    // mixed sizes back to back
    prdata = 32'h11223344;
    @(posedge clk);
    #1;
    push(1'b1, 32'h203, 2'd1, 32'h1234,
         bus_t'{1'b1, 32'h202, 4'hC, 32'h12340000},
         rsp_t'{32'h0, 1'b0, 1'b0}, 1'b1, 1'b1);
    push(1'b0, 32'h106, 2'd1, 32'h0,
         bus_t'{1'b0, 32'h106, 4'h0, 32'h0},
         rsp_t'{32'h00001122, 1'b0, 1'b0}, 1'b1, 1'b1);
    push(1'b0, 32'h101, 2'd0, 32'h0,
         bus_t'{1'b0, 32'h101, 4'h0, 32'h0},
         rsp_t'{32'h00000033, 1'b0, 1'b0}, 1'b1, 1'b1);
    push(1'b0, 32'h17, 2'd3, 32'h0,
         bus_t'{1'b0, 32'h14, 4'h0, 32'h0},
         rsp_t'{32'h11223344, 1'b0, 1'b0}, 1'b1, 1'b1);
    push(1'b0, 32'h1, 2'd2, 32'h0,
         bus_t'{1'b0, 32'h0, 4'h0, 32'h0},
         rsp_t'{32'h11223344, 1'b0, 1'b0}, 1'b1, 1'b1);
    push(1'b1, 32'h8, 2'd3, 32'hA1B2C3D4,
         bus_t'{1'b1, 32'h8, 4'hF, 32'hA1B2C3D4},
         rsp_t'{32'h0, 1'b0, 1'b0}, 1'b1, 1'b1);
    wait_idle();

    // burst into a full FIFO, first transfer stalled
    b0 = rsp_cyc_q.size();
    pready = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      push(1'b1, 32'h400 + 32'(4 * i), 2'd2, 32'h1000 + 32'(i),
           bus_t'{1'b1, 32'h400 + 32'(4 * i), 4'hF, 32'h1000 + 32'(i)},
           rsp_t'{32'h0, 1'b0, 1'b0}, 1'b1, 1'b1);
    end
    fork
      push(1'b1, 32'h414, 2'd2, 32'h1005,
           bus_t'{1'b1, 32'h414, 4'hF, 32'h1005},
           rsp_t'{32'h0, 1'b0, 1'b0}, 1'b1, 1'b1);
      begin
        @(negedge clk);
        chk("full_level", fifo_level, 4);
        chk("full_ready", cmd_ready, 0);
        @(negedge clk);
        chk("full_ready_held", cmd_ready, 0);
        @(posedge clk);
        #1 pready = 1'b1;
        @(negedge clk);
        chk("ready_low_on_pop", cmd_ready, 0);
      end
    join
    wait_idle();
    chk("burst_count", rsp_cyc_q.size() - b0, 6);
    for (int i = 1; i < 6; i++) begin
      if (rsp_cyc_q.size() > b0 + i) begin
        chk("burst_spacing", rsp_cyc_q[b0 + i] - rsp_cyc_q[b0 + i - 1], 2);
      end
    end

    // slave error after three wait states
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    push(1'b0, 32'h20, 2'd2, 32'h0,
         bus_t'{1'b0, 32'h20, 4'h0, 32'h0},
         rsp_t'{32'hCAFEF00D, 1'b1, 1'b0}, 1'b1, 1'b1);
    acc = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      pready  = (k == 5);
      pslverr = (k == 5);
      @(negedge clk);
      if (penable) acc++;
    end
    pready  = 1'b1;
    pslverr = 1'b0;
    chk("err_access_cycles", acc, 4);
    wait_idle();

`ifdef APB_TIMEOUT_EN
    pready = 1'b0;
    prdata = 32'h55AA55AA;
    @(posedge clk);
    #1;
    push(1'b0, 32'h30, 2'd2, 32'h0,
         bus_t'{1'b0, 32'h30, 4'h0, 32'h0},
         rsp_t'{32'h0, 1'b1, 1'b1}, 1'b1, 1'b1);
    acc = 0;
    nr  = 0;
    do begin
      @(negedge clk);
      nr++;
      if (penable) acc++;
    end while (rsp_valid !== 1'b1 && nr < 60);
    chk("to_bounded", 64'(nr < 60), 1);
    chk("to_access_cycles", acc, TO);
    pready = 1'b1;
    wait_idle();
`endif

    // reset during ACCESS with two commands queued
    pready = 1'b0;
    @(posedge clk);
    #1;
    push(1'b1, 32'h500, 2'd2, 32'h77,
         bus_t'{1'b1, 32'h500, 4'hF, 32'h77},
         rsp_t'{32'h0, 1'b0, 1'b0}, 1'b1, 1'b0);
    push(1'b1, 32'h504, 2'd2, 32'h78,
         bus_t'{1'b1, 32'h504, 4'hF, 32'h78},
         rsp_t'{32'h0, 1'b0, 1'b0}, 1'b0, 1'b0);
    push(1'b0, 32'h508, 2'd2, 32'h0,
         bus_t'{1'b0, 32'h508, 4'h0, 32'h0},
         rsp_t'{32'h0, 1'b0, 1'b0}, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_level", fifo_level, 2);
    chk("pre_rst_access", {psel, penable}, 2'b11);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_psel", {psel, penable}, 2'b00);
    chk("rst_level", fifo_level, 0);
    chk("rst_no_rsp", rsp_valid, 0);
    chk("rst_ready_low", cmd_ready, 0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    pready = 1'b1;
    nr = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) nr++;
    end
    chk("post_rst_rsp_count", nr, 0);
    chk("post_rst_idle", busy, 0);

    chk("rsp_q_drained", rsp_q.size(), 0);
    chk("bus_q_drained", bus_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
